m65c02_irq_rqst_ctrl: RTL and testbench
=======================================

// Module: m65c02_irq_rqst_ctrl
// PURPOSE
//  Peripheral-side interrupt request controller: the source end of the core's
//  RQST[7:0] interrupt interface. Captures 8 peripheral interrupt sources as
//  edge- or level-sensitive with per-source polarity. Holds pending/enable state
//  and drives RQST[7:0] into the core interrupt handler. Retires edge requests
//  on vector fetch (VP) or by a CPU write-1-to-clear through an 8-bit register port.
// PARAMETERS
//  pVEC_BASE  16'hFFE0  address of RQST[0] vector low byte; RQST[n] at pVEC_BASE+2n
//  pRST_MODE  8'h00     reset MODE register (1 = edge, 0 = level)
//  pRST_POL   8'hFF     reset POL register (1 = active-high/rising, 0 = low/falling)
// PORTS
//  Clk    in   1   system clock; all flops on rising edge
//  Rst    in   1   asynchronous, active-high reset
//  Rdy    in   1   core ready; qualifies WE and the VP acknowledge
//  Src    in   8   peripheral interrupt sources
//  Sel    in   1   register port select
//  WE     in   1   register write strobe (effective when Sel & WE & Rdy)
//  Addr   in   2   0:PEND 1:ENA 2:MODE 3:POL
//  DI     in   8   write data
//  DO     out  8   read data, combinational mux of Addr; 8'h00 when ~Sel
//  VP     in   1   core vector pull
//  AB     in   16  core address bus
//  RQST   out  8   interrupt requests to core, = PEND & ENA
//  Any    out  1   |RQST
// BEHAVIOUR
//  - Reset: PEND=0, ENA=0, MODE=pRST_MODE, POL=pRST_POL, sample/sync flops=0.
//    Hence RQST=0, Any=0, DO=0. Reset is asynchronous and wins mid-operation.
//  - Act[n] = Src_s[n] ~^ POL[n]. Src_s is the (optionally synchronized) source.
//    Act_Q is Act registered one clock.
//  - Edge mode (MODE[n]=1): Set[n] = Act[n] & ~Act_Q[n]. Clr[n] = W1C | Ack[n].
//    PEND[n] <= Set[n] | (PEND[n] & ~Clr[n]): set wins over simultaneous clear.
//  - Level mode (MODE[n]=0): PEND[n] <= Act[n] every clock.
//    W1C and Ack have no effect.
//  - W1C: write Addr 0 with DI[n]=1 clears PEND[n] (edge mode only).
//    DI[n]=0 leaves it unchanged.
//  - Ack[n] = VP & Rdy & (AB == pVEC_BASE + 2n). Low-byte fetch only; the
//    high-byte fetch (+1) is ignored. Addresses outside the 16-byte table: no effect.
//  - Writes to ENA/MODE/POL take effect the following clock. A POL or MODE change
//    can create a spurious edge; software clears PEND afterwards.
//  - ENA masks RQST only. PEND still captures events while disabled, and enabling
//    later presents the held request.
//  - Latency without sync: Src edge set up before clock k -> PEND and RQST high
//    after edge k (1 clk).
//  - Ack/W1C at edge k -> RQST low after edge k.
//  - Src pulse of >= 1 clk is captured in edge mode. In level mode RQST tracks Src,
//    delayed by 1 clk.
//  - Arithmetic: vector compare uses 16-bit unsigned add, no wrap handling needed
//    (pVEC_BASE <= 16'hFFF0).
// CONFIGURATION
//  M65C02_IRQ_SYNC_EN defined: each Src bit passes a 2-flop synchronizer before Act.
//    Latency becomes 3 clk. Reset clears the synchronizers.
//  Undefined: Src_s = Src (sources are synchronous to Clk), latency 1 clk.
// TESTING
//  1 Reset: Rst=1 with Src=8'hFF -> RQST=0, DO(Addr 1..3)=00/pRST_MODE/pRST_POL.
//  2 MODE=FF, ENA=01, rising Src[0]: 1-clk pulse -> RQST=8'h01 after 1 clk
//    (3 with SYNC_EN). Holds after Src drops. W1C DI=01 -> RQST=0 next clk.
//  3 Edge mode: VP=1, Rdy=1, AB=pVEC_BASE+6 -> PEND[3] clears.
//    Same with Rdy=0 or AB=+7 -> PEND[3] stays set.
//  4 Simultaneous new edge on Src[2] and W1C DI=04 in same clk -> PEND[2] remains 1.
//  5 Level mode, POL[5]=0: Src[5]=0 -> RQST[5]=1 after 1 clk.
//    W1C ignored; Src[5]=1 -> RQST[5]=0.
//  6 ENA=00, edge on Src[7] -> RQST=0, PEND=80. Write ENA=80 -> RQST=80 next clk.
//    Assert Rst mid-request -> RQST=0 immediately.

Source files
------------

// File: rtl/m65c02_irq_rqst_ctrl.sv
// rtl/m65c02_irq_rqst_ctrl.sv - 8-source edge/level interrupt request controller driving RQST[7:0]
// Optional 2-flop source synchronizers: define M65C02_IRQ_SYNC_EN.
module m65c02_irq_rqst_ctrl #(
  parameter logic [15:0] pVEC_BASE = 16'hFFE0,
  parameter logic [7:0]  pRST_MODE = 8'h00,
  parameter logic [7:0]  pRST_POL  = 8'hFF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Rdy,
  input  logic [7:0]  Src,
  input  logic        Sel,
  input  logic        WE,
  input  logic [1:0]  Addr,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  input  logic        VP,
  input  logic [15:0] AB,
  output logic [7:0]  RQST,
  output logic        Any
);

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_ENA  = 2'd1;
  localparam logic [1:0] ADDR_MODE = 2'd2;
  localparam logic [1:0] ADDR_POL  = 2'd3;

  logic [7:0] pend_q, pend_d;
  logic [7:0] ena_q,  ena_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] pol_q,  pol_d;
  logic [7:0] act_q,  act_d;

  logic [7:0] src_s;
  logic [7:0] act;
  logic [7:0] set_evt;
  logic [7:0] clr_evt;
  logic [7:0] ack;
  logic [7:0] w1c;
  logic       wr_en;

`ifdef M65C02_IRQ_SYNC_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = Src;
    sync2_d = sync1_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = Src;
`endif

  assign wr_en = Sel & WE & Rdy;

  // Only the low-byte fetch of each vector retires its request.
  always_comb begin
    ack = 8'h00;
    for (int n = 0; n < 8; n++) begin
      ack[n] = VP & Rdy & (AB == (pVEC_BASE + 16'(2 * n)));
    end
  end

  always_comb begin
    act     = src_s ~^ pol_q;
    act_d   = act;
    set_evt = act & ~act_q;
    w1c     = (wr_en && (Addr == ADDR_PEND)) ? DI : 8'h00;
    clr_evt = w1c | ack;
  end

  // Edge sources: a new edge beats a simultaneous clear. Level sources follow Act.
  always_comb begin
    pend_d = pend_q;
    for (int n = 0; n < 8; n++) begin
      if (mode_q[n]) begin
        pend_d[n] = set_evt[n] | (pend_q[n] & ~clr_evt[n]);
      end else begin
        pend_d[n] = act[n];
      end
    end
  end

  always_comb begin
    ena_d  = ena_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    if (wr_en) begin
      case (Addr)
        ADDR_ENA:  ena_d  = DI;
        ADDR_MODE: mode_d = DI;
        ADDR_POL:  pol_d  = DI;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pend_q <= 8'h00;
      ena_q  <= 8'h00;
      mode_q <= pRST_MODE;
      pol_q  <= pRST_POL;
      act_q  <= 8'h00;
    end else begin
      pend_q <= pend_d;
      ena_q  <= ena_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      act_q  <= act_d;
    end
  end

  always_comb begin
    DO = 8'h00;
    if (Sel) begin
      case (Addr)
        ADDR_PEND: DO = pend_q;
        ADDR_ENA:  DO = ena_q;
        ADDR_MODE: DO = mode_q;
        ADDR_POL:  DO = pol_q;
        default:   DO = 8'h00;
      endcase
    end
  end

  assign RQST = pend_q & ena_q;
  assign Any  = |RQST;

endmodule

// File: tb/tb_m65c02_irq_rqst_ctrl.sv
// tb/tb_m65c02_irq_rqst_ctrl.sv - scoreboard bench for m65c02_irq_rqst_ctrl
module tb_m65c02_irq_rqst_ctrl;

`ifdef M65C02_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Rdy;
  logic [7:0]  Src;
  logic        Sel;
  logic        WE;
  logic [1:0]  Addr;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        VP;
  logic [15:0] AB;
  logic [7:0]  RQST;
  logic        Any;

  m65c02_irq_rqst_ctrl #(
    .pVEC_BASE(16'hFFE0),
    .pRST_MODE(8'h00),
    .pRST_POL (8'hFF)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .Rdy (Rdy),
    .Src (Src),
    .Sel (Sel),
    .WE  (WE),
    .Addr(Addr),
    .DI  (DI),
    .DO  (DO),
    .VP  (VP),
    .AB  (AB),
    .RQST(RQST),
    .Any (Any)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  event go;

  // Monitor: pops every queued expectation when the stimulus presents a sample point.
  initial begin
    exp_t it;
    logic [7:0] act;
    forever begin
      @(go);
      while (q.size() > 0) begin
        it = q.pop_front();
        case (it.kind)
          0:       act = RQST;
          1:       act = {7'd0, Any};
          default: act = DO;
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %02h expected %02h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic push(input int kind, input logic [7:0] exp, input string name);
    exp_t it;
    it.kind = kind;
    it.exp  = exp;
    it.name = name;
    q.push_back(it);
  endtask

  task automatic sample();
    #1;
    -> go;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    Sel = 1'b1; WE = 1'b1; Addr = a; DI = d;
    tick();
    Sel = 1'b0; WE = 1'b0; DI = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    Sel = 1'b1; WE = 1'b0; Addr = a;
    push(2, exp, name);
    sample();
    Sel = 1'b0;
  endtask

  task automatic chk_rq(input logic [7:0] exp, input string name);
    push(0, exp, name);
    push(1, {7'd0, |exp}, {name, "_any"});
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; Rdy = 1'b1; Src = 8'hFF; Sel = 1'b0; WE = 1'b0;
    Addr = 2'd0; DI = 8'h00; VP = 1'b0; AB = 16'h0000;

    // Reset state with all sources asserted
    tick(); tick();
    chk_rq(8'h00, "rst_rqst");
    rd(2'd0, 8'h00, "rst_pend");
    rd(2'd1, 8'h00, "rst_ena");
    rd(2'd2, 8'h00, "rst_mode");
    rd(2'd3, 8'hFF, "rst_pol");
    Src = 8'h00;
    tick();
    Rst = 1'b0;
    tick();
    Addr = 2'd3;
    push(2, 8'h00, "do_unsel");
    sample();

    // Edge capture of a 1-clk pulse, hold, then W1C
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'h01);
    Src = 8'h01;
    chk_rq(8'h00, "edge_pre");
    tick();
    Src = 8'h00;
    repeat (LAT - 1) tick();
    chk_rq(8'h01, "edge_set");
    tick(); tick();
    chk_rq(8'h01, "edge_hold");
    wr(2'd0, 8'h01);
    chk_rq(8'h00, "edge_w1c");

    // Vector-pull acknowledge qualifications
    wr(2'd1, 8'hFF);
    Src = 8'h08;
    repeat (LAT) tick();
    rd(2'd0, 8'h08, "ack_pend_set");
    chk_rq(8'h08, "ack_rqst_set");
    VP = 1'b1; Rdy = 1'b0; AB = 16'hFFE6;
    tick();
    VP = 1'b0; Rdy = 1'b1;
    rd(2'd0, 8'h08, "ack_rdy0");
    VP = 1'b1; AB = 16'hFFE7;
    tick();
    VP = 1'b0;
    rd(2'd0, 8'h08, "ack_hibyte");
    VP = 1'b1; AB = 16'hFFE6;
    tick();
    VP = 1'b0; AB = 16'h0000;
    rd(2'd0, 8'h00, "ack_clear");
    chk_rq(8'h00, "ack_rqst_clr");
    Src = 8'h00;
    repeat (LAT) tick();

    // New edge and W1C in the same clock: set wins
    Src = 8'h04;
    repeat (LAT - 1) tick();
    wr(2'd0, 8'h04);
    rd(2'd0, 8'h04, "set_wins");
    wr(2'd0, 8'h04);
    rd(2'd0, 8'h00, "w1c_after");
    Src = 8'h00;
    repeat (LAT) tick();

    // Level mode, active-low on source 5
    wr(2'd2, 8'hDF);
    wr(2'd3, 8'hDF);
    tick();
    chk_rq(8'h20, "lvl_active");
    wr(2'd0, 8'h20);
    chk_rq(8'h20, "lvl_w1c_ign");
    Src = 8'h20;
    chk_rq(8'h20, "lvl_pre");
    repeat (LAT) tick();
    chk_rq(8'h00, "lvl_inactive");

    // Masked capture, late enable, async reset mid-request
    Src = 8'h00;
    repeat (LAT) tick();
    wr(2'd3, 8'hFF);
    wr(2'd2, 8'hFF);
    rd(2'd0, 8'h00, "restore_pend");
    wr(2'd1, 8'h00);
    Src = 8'h80;
    repeat (LAT) tick();
    chk_rq(8'h00, "mask_rqst");
    rd(2'd0, 8'h80, "mask_pend");
    wr(2'd1, 8'h80);
    chk_rq(8'h80, "unmask_rqst");
    Rst = 1'b1;
    chk_rq(8'h00, "async_rst");
    rd(2'd0, 8'h00, "async_rst_pend");
    rd(2'd1, 8'h00, "async_rst_ena");
    tick();
    Rst = 1'b0;
    tick();

    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
